// File: rtl/mont_exp_ctrl.sv
// Left-to-right binary modular exponentiation sequencer driving a shared Montgomery multiplier.
// Optional busy-cycle and multiplication counters are enabled with MEXP_CYCLE_CNT_EN.
module mont_exp_ctrl #(
  parameter int WIDTH = 1024,
  parameter int EXP_W = 1024,
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [LEN_W-1:0] exp_len,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] n_in,
  input  logic [WIDTH-1:0] r2n_in,
  input  logic [WIDTH-1:0] rn_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_m,
  input  logic [WIDTH-1:0] mm_result,
  input  logic             mm_done
`ifdef MEXP_CYCLE_CNT_EN
  ,
  output logic [31:0]      cycle_cnt,
  output logic [15:0]      mm_cnt
`endif
);

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [LEN_W-1:0] EXP_W_L = LEN_W'(EXP_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_TOMONT = 2'd0,
    OP_SQ     = 2'd1,
    OP_MUL    = 2'd2,
    OP_POST   = 2'd3
  } op_t;

  state_t             state_r, state_nxt_s;
  op_t                op_r, op_nxt_s;
  logic [IDX_W-1:0]   idx_r, idx_nxt_s, idx_first_s;
  logic [LEN_W-1:0]   len_r, len_clamp_s;
  logic [EXP_W-1:0]   e_r;
  logic [WIDTH-1:0]   n_r, x_r, r2n_r, xt_r, a_r, result_r;
  logic [WIDTH-1:0]   mm_a_r, mm_b_r, opa_s, opb_s;
  logic               busy_r, done_r, mm_start_r;
  logic               accept_s, issue_s, capture_s, finish_s;

  // Exponent length clamp and first bit index
  always_comb begin
    if (exp_len > EXP_W_L) begin
      len_clamp_s = EXP_W_L;
    end else begin
      len_clamp_s = exp_len;
    end
    if (len_clamp_s == {LEN_W{1'b0}}) begin
      idx_first_s = {IDX_W{1'b0}};
    end else begin
      idx_first_s = IDX_W'(len_clamp_s - LEN_W'(1'b1));
    end
  end

  // Operand selection for the op being issued
  always_comb begin
    opa_s = {WIDTH{1'b0}};
    opb_s = {WIDTH{1'b0}};
    case (op_r)
      OP_TOMONT: begin opa_s = x_r; opb_s = r2n_r; end
      OP_SQ:     begin opa_s = a_r; opb_s = a_r;   end
      OP_MUL:    begin opa_s = a_r; opb_s = xt_r;  end
      OP_POST:   begin opa_s = a_r; opb_s = WIDTH'(1'b1); end
      default:   begin opa_s = {WIDTH{1'b0}}; opb_s = {WIDTH{1'b0}}; end
    endcase
  end

  // Next-state, next-op and bit-index decisions
  always_comb begin
    state_nxt_s = state_r;
    op_nxt_s    = op_r;
    idx_nxt_s   = idx_r;
    accept_s    = 1'b0;
    issue_s     = 1'b0;
    capture_s   = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_ISSUE;
          op_nxt_s    = OP_TOMONT;
          idx_nxt_s   = idx_first_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        issue_s     = 1'b1;
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (mm_done) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_ISSUE;
          case (op_r)
            OP_TOMONT: begin
              if (len_r != {LEN_W{1'b0}}) begin
                op_nxt_s = OP_SQ;
              end else begin
                op_nxt_s = OP_POST;
              end
            end
            OP_SQ: begin
              if (e_r[idx_r]) begin
                op_nxt_s = OP_MUL;
              end else if (idx_r == {IDX_W{1'b0}}) begin
                op_nxt_s = OP_POST;
              end else begin
                op_nxt_s  = OP_SQ;
                idx_nxt_s = idx_r - IDX_W'(1'b1);
              end
            end
            OP_MUL: begin
              // Zero test comes first so the index never wraps
              if (idx_r == {IDX_W{1'b0}}) begin
                op_nxt_s = OP_POST;
              end else begin
                op_nxt_s  = OP_SQ;
                idx_nxt_s = idx_r - IDX_W'(1'b1);
              end
            end
            OP_POST: begin
              finish_s    = 1'b1;
              state_nxt_s = ST_DONE;
            end
            default: begin
              state_nxt_s = ST_IDLE;
            end
          endcase
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, current op and bit index
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      op_r    <= OP_TOMONT;
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      op_r    <= op_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Operand latches, accumulators and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_r        <= {EXP_W{1'b0}};
      len_r      <= {LEN_W{1'b0}};
      n_r        <= {WIDTH{1'b0}};
      x_r        <= {WIDTH{1'b0}};
      r2n_r      <= {WIDTH{1'b0}};
      xt_r       <= {WIDTH{1'b0}};
      a_r        <= {WIDTH{1'b0}};
      result_r   <= {WIDTH{1'b0}};
      mm_a_r     <= {WIDTH{1'b0}};
      mm_b_r     <= {WIDTH{1'b0}};
      mm_start_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      mm_start_r <= issue_s;
      done_r     <= finish_s;
      if (accept_s) begin
        e_r    <= exp_in;
        len_r  <= len_clamp_s;
        n_r    <= n_in;
        x_r    <= x_in;
        r2n_r  <= r2n_in;
        a_r    <= rn_in;
        busy_r <= 1'b1;
      end else if (finish_s) begin
        busy_r <= 1'b0;
      end
      if (issue_s) begin
        mm_a_r <= opa_s;
        mm_b_r <= opb_s;
      end
      if (capture_s) begin
        case (op_r)
          OP_TOMONT: xt_r     <= mm_result;
          OP_SQ:     a_r      <= mm_result;
          OP_MUL:    a_r      <= mm_result;
          OP_POST:   result_r <= mm_result;
          default:   a_r      <= a_r;
        endcase
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign result   = result_r;
  assign mm_start = mm_start_r;
  assign mm_a     = mm_a_r;
  assign mm_b     = mm_b_r;
  assign mm_m     = n_r;

`ifdef MEXP_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_r;
  logic [15:0] mm_cnt_r;

  // Saturating busy-cycle and multiplication counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cycle_cnt_r <= 32'd0;
      mm_cnt_r    <= 16'd0;
    end else if (accept_s) begin
      cycle_cnt_r <= 32'd0;
      mm_cnt_r    <= 16'd0;
    end else begin
      if ((state_r != ST_IDLE) && (cycle_cnt_r != 32'hFFFF_FFFF)) begin
        cycle_cnt_r <= cycle_cnt_r + 32'd1;
      end
      if (issue_s && (mm_cnt_r != 16'hFFFF)) begin
        mm_cnt_r <= mm_cnt_r + 16'd1;
      end
    end
  end

  assign cycle_cnt = cycle_cnt_r;
  assign mm_cnt    = mm_cnt_r;
`endif

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Self-checking bench for mont_exp_ctrl with a 16-bit behavioural Montgomery multiplier (5-cycle latency).
module tb_mont_exp_ctrl;

  localparam int W   = 16;
  localparam int EW  = 16;
  localparam int LW  = 5;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [LW-1:0] exp_len;
  logic [EW-1:0] exp_in;
  logic [W-1:0]  x_in, n_in, r2n_in, rn_in;
  logic          busy, done, mm_start, mm_done;
  logic [W-1:0]  result, mm_a, mm_b, mm_m, mm_result;
`ifdef MEXP_CYCLE_CNT_EN
  logic [31:0]   cycle_cnt;
  logic [15:0]   mm_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int mm_pulses = 0;
  int done_pulses = 0;
  int lat_cnt;
  logic [W-1:0] mm_pend;

  mont_exp_ctrl #(.WIDTH(W), .EXP_W(EW), .LEN_W(LW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .exp_len(exp_len), .exp_in(exp_in),
    .x_in(x_in), .n_in(n_in), .r2n_in(r2n_in), .rn_in(rn_in),
    .busy(busy), .done(done), .result(result),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done)
`ifdef MEXP_CYCLE_CNT_EN
    , .cycle_cnt(cycle_cnt), .mm_cnt(mm_cnt)
`endif
  );

  always #5 clk = ~clk;

  // a*b*2^-16 mod m by bitwise reduction on plain integers
  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
    longint t;
    t = longint'(a) * longint'(b);
    for (int k = 0; k < W; k++) begin
      if (t % 2 == 1) t = t + longint'(m);
      t = t / 2;
    end
    if (t >= longint'(m)) t = t - longint'(m);
    return W'(t);
  endfunction

  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] x, input logic [EW-1:0] e, input int len, input logic [W-1:0] n);
    longint r, b;
    r = 1 % longint'(n);
    b = longint'(x) % longint'(n);
    for (int i = 0; i < len; i++) begin
      if (e[i]) r = (r * b) % longint'(n);
      b = (b * b) % longint'(n);
    end
    return W'(r);
  endfunction

  // Behavioural multiplier: result and done pulse LAT cycles after mm_start
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lat_cnt   <= 0;
      mm_done   <= 1'b0;
      mm_result <= '0;
      mm_pend   <= '0;
    end else begin
      mm_done <= 1'b0;
      if (mm_start) begin
        lat_cnt <= LAT - 1;
        mm_pend <= mont(mm_a, mm_b, mm_m);
      end else if (lat_cnt > 0) begin
        lat_cnt <= lat_cnt - 1;
        if (lat_cnt == 1) begin
          mm_done   <= 1'b1;
          mm_result <= mm_pend;
        end
      end
    end
  end

  // Running pulse counters
  always @(posedge clk) begin
    if (mm_start) mm_pulses <= mm_pulses + 1;
    if (done) done_pulses <= done_pulses + 1;
  end

  task automatic load_inputs(input logic [W-1:0] n, input logic [W-1:0] x, input logic [EW-1:0] e, input logic [LW-1:0] len);
    longint rr;
    rr      = 65536 % longint'(n);
    exp_len = len;
    exp_in  = e;
    x_in    = x;
    n_in    = n;
    rn_in   = W'(rr);
    r2n_in  = W'((rr * rr) % longint'(n));
  endtask

  task automatic run_exp(input string tag, input logic [W-1:0] n, input logic [W-1:0] x,
                         input logic [EW-1:0] e, input logic [LW-1:0] len, input int extra_at);
    int eff_len, ones, exp_cnt, p0, d0, cyc;
    logic [W-1:0] exp_res;
    logic got;
    eff_len = (int'(len) > EW) ? EW : int'(len);
    ones = 0;
    for (int i = 0; i < eff_len; i++) if (e[i]) ones++;
    exp_cnt = 2 + eff_len + ones;
    exp_res = ref_pow(x, e, eff_len, n);
    @(negedge clk);
    load_inputs(n, x, e, len);
    start = 1'b1;
    p0 = mm_pulses;
    d0 = done_pulses;
    @(negedge clk);
    start  = 1'b0;
    x_in   = W'($urandom);
    n_in   = W'($urandom);
    exp_in = EW'($urandom);
    r2n_in = W'($urandom);
    rn_in  = W'($urandom);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy_after_start: got %b want 1", tag, busy); end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = (extra_at > 0 && cyc == extra_at) ? 1'b1 : 1'b0;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s timeout: no done after %0d cycles", tag, cyc);
      return;
    end
    n_cmp++;
    if (result !== exp_res) begin n_err++; $display("FAIL %s result: got %0d want %0d", tag, result, exp_res); end
    n_cmp++;
    if (cyc != 7 * exp_cnt) begin n_err++; $display("FAIL %s latency: got %0d want %0d", tag, cyc, 7 * exp_cnt); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy_in_done: got %b want 0", tag, busy); end
    @(negedge clk);
    n_cmp++;
    if (mm_pulses - p0 != exp_cnt) begin n_err++; $display("FAIL %s mm_starts: got %0d want %0d", tag, mm_pulses - p0, exp_cnt); end
    n_cmp++;
    if (done_pulses - d0 != 1 || done !== 1'b0) begin
      n_err++; $display("FAIL %s done_pulse: got %0d pulses (done=%b) want 1", tag, done_pulses - d0, done);
    end
    n_cmp++;
    if (busy !== 1'b0 || result !== exp_res) begin
      n_err++; $display("FAIL %s hold: busy=%b result=%0d want 0/%0d", tag, busy, result, exp_res);
    end
`ifdef MEXP_CYCLE_CNT_EN
    n_cmp++;
    if (mm_cnt !== 16'(exp_cnt) || cycle_cnt !== 32'(7 * exp_cnt + 1)) begin
      n_err++; $display("FAIL %s counters: mm_cnt=%0d cycle_cnt=%0d want %0d/%0d", tag, mm_cnt, cycle_cnt, exp_cnt, 7 * exp_cnt + 1);
    end
`endif
  endtask

  task automatic test_reset();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || mm_start !== 1'b0 || result !== '0) begin
      n_err++; $display("FAIL reset_ctrl: busy=%b done=%b mm_start=%b result=%0d want all 0", busy, done, mm_start, result);
    end
    n_cmp++;
    if (mm_a !== '0 || mm_b !== '0 || mm_m !== '0) begin
      n_err++; $display("FAIL reset_operands: a=%0d b=%0d m=%0d want 0", mm_a, mm_b, mm_m);
    end
  endtask

  task automatic test_known();
    run_exp("e13_len4", 16'd1009, 16'd2, 16'd13, 5'd4, 0);
    run_exp("e13_len8", 16'd1009, 16'd2, 16'd13, 5'd8, 0);
    run_exp("e0_len0", 16'd1009, 16'd2, 16'd0, 5'd0, 0);
    run_exp("e1_len1", 16'd1009, 16'd2, 16'd1, 5'd1, 0);
  endtask

  task automatic test_start_while_busy();
    run_exp("start_busy", 16'd1009, 16'd2, 16'd13, 5'd4, 10);
  endtask

  task automatic test_reset_abort();
    int p0, cyc;
    @(negedge clk);
    load_inputs(16'd1009, 16'd2, 16'd13, 5'd4);
    start = 1'b1;
    p0 = mm_pulses;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(mm_start === 1'b1 && mm_pulses - p0 == 2) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (cyc >= 200) begin n_err++; $display("FAIL abort_wait: third mm_start not seen"); end
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || mm_start !== 1'b0) begin
      n_err++; $display("FAIL abort_immediate: busy=%b mm_start=%b want 0/0", busy, mm_start);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    run_exp("after_abort", 16'd1009, 16'd2, 16'd13, 5'd4, 0);
  endtask

  task automatic test_clamp();
    run_exp("clamp31", 16'd40961, 16'd12345, EW'($urandom), 5'd31, 0);
    run_exp("clamp17", 16'd65521, 16'd777, EW'($urandom), 5'd17, 0);
  endtask

  task automatic test_random();
    logic [W-1:0] n, x;
    for (int k = 0; k < 8; k++) begin
      n = W'($urandom_range(32767, 1) * 2 + 1);
      x = W'($urandom % int'(n));
      run_exp("random", n, x, EW'($urandom), LW'($urandom_range(16, 0)), 0);
    end
  endtask

  initial begin
    resetn  = 1'b0;
    start   = 1'b0;
    exp_len = '0;
    exp_in  = '0;
    x_in    = '0;
    n_in    = '0;
    r2n_in  = '0;
    rn_in   = '0;
    repeat (3) @(negedge clk);
    test_reset();
    resetn = 1'b1;
    test_known();
    test_start_while_busy();
    test_reset_abort();
    test_clamp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
